div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal range 2..64).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset (`RstEnable` = 1'b1).
REQ-005 SHALL have port signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 SHALL have port opdata1_i  input  WIDTH  dividend; sampled with start.
REQ-007 SHALL have port opdata2_i  input  WIDTH  divisor; sampled with start.
REQ-008 SHALL have port start_i  input  1  request/hold from EX (`DivStart`/`DivStop`).
REQ-009 SHALL have port annul_i  input  1  cancel in-flight division (flush).
REQ-010 SHALL have port result_o  output  2*WIDTH  {remainder, quotient}, for HI/LO.
REQ-011 SHALL have port ready_o  output  1  result valid (`DivResultReady`).

Function
REQ-012 SHALL implement a 4-state FSM: DivFree, DivByZero, DivOn, DivEnd, with registered outputs.
REQ-013 In DivFree, with start_i=1 and annul_i=0, SHALL capture the operands and mode, then go to DivByZero if the divisor is 0, else go to DivOn with iteration counter cnt=0.
REQ-014 In DivFree, with start_i=0 or annul_i=1, SHALL stay in DivFree with ready_o=0 and result_o=0.
REQ-015 In signed mode, SHALL convert negative operands to magnitude (two's complement) on capture; in unsigned mode SHALL use them as-is.
REQ-016 In DivOn with cnt<WIDTH, each cycle SHALL do one restoring shift-subtract step: shift the partial remainder left by one and bring in the next dividend bit (MSB first); if the remainder is >= the divisor magnitude, subtract it and set quotient bit 1, else set quotient bit 0; then cnt++.
REQ-017 In DivOn with cnt==WIDTH, SHALL apply sign fix and go to DivEnd.
REQ-018 Sign fix: quotient negated iff signed and dividend/divisor signs differ; remainder negated iff signed and dividend negative.
REQ-019 SHALL treat signed MIN/-1 as wrapping: quotient = MIN (0x80000000 at WIDTH=32), remainder = 0; no trap or flag.
REQ-020 DivByZero SHALL go to DivEnd the next cycle with result_o=0.
REQ-021 In DivEnd, SHALL drive ready_o=1 and hold result_o stable while start_i=1.
REQ-022 In DivEnd with start_i=0, SHALL go to DivFree with ready_o=0 and result_o=0 on the next edge.
REQ-023 Latency: ready_o SHALL rise WIDTH+2 cycles after the start-sampling edge (34 at WIDTH=32), or 2 cycles after it for divide-by-zero.
REQ-024 annul_i=1 in DivOn or DivByZero SHALL return the FSM to DivFree on the next edge; ready_o SHALL never assert for that operation.
REQ-025 annul_i in DivEnd SHALL be ignored; only start_i=0 exits DivEnd.
REQ-026 Operand changes after capture SHALL NOT affect the result.
REQ-027 A new start SHALL be accepted no earlier than the cycle after the FSM returns to DivFree.

Reset
REQ-028 rst=1 at a clock edge SHALL force DivFree, cnt=0, ready_o=0, result_o=0 and clear all datapath registers, regardless of state, including mid-operation.
REQ-029 Reset SHALL take precedence over start_i and annul_i in the same cycle.

Structure
REQ-030 The shared defines header SHALL hold the state encodings DivFree/DivByZero/DivOn/DivEnd and the constants DivResultReady/NotReady and DivStart/DivStop.
REQ-031 The single-iteration compare/subtract datapath SHALL be a combinational sub-module div_step, parametrised by WIDTH.
REQ-032 cnt SHALL be $clog2(WIDTH+1) bits wide.

Verification (WIDTH=32 unless stated)
REQ-033 Unsigned 100/7 -> result_o={0x00000002,0x0000000E}; ready_o rises exactly 34 cycles after start.
REQ-034 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-035 Divide by zero, 5/0 (either mode) -> result_o=0, ready_o rises 2 cycles after start.
REQ-036 Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-037 annul_i pulse at iteration 10 -> ready_o stays 0 and FSM returns to DivFree; a subsequent 9/3 -> quotient 3, remainder 0 after 34 cycles.
REQ-038 rst at iteration 20 -> ready_o=0 and result_o=0 the next cycle; holding start_i in DivEnd -> result held stable for 5 cycles; deasserting start_i -> ready_o falls next cycle; WIDTH=8 signed -128/3 -> quotient 0xD6 (-42), remainder 0xFE (-2), latency 10.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared encodings and handshake constants for the
// multi-cycle integer divider.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift-subtract step: bring in a dividend bit,
// conditionally subtract the divisor, emit one quotient bit.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             din,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] sh;
   logic [WIDTH:0] diff;

   assign sh   = {rem, din};
   assign diff = sh - {1'b0, dvs};

   // rem < dvs keeps sh below 2*dvs, so bit WIDTH is a clean borrow
   assign q_bit    = ~diff[WIDTH];
   assign rem_next = q_bit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for the EX stage,
// returns {remainder, quotient} for HI/LO.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int CW = $clog2(WIDTH + 1);

   div_state_e state;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] rem_next;
   logic q_bit;
   logic q_neg;
   logic r_neg;
   logic [2*WIDTH-1:0] res;

   logic neg1;
   logic neg2;
   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign neg1  = signed_div_i & opdata1_i[WIDTH-1];
   assign neg2  = signed_div_i & opdata2_i[WIDTH-1];
   assign mag1  = neg1 ? -opdata1_i : opdata1_i;
   assign mag2  = neg2 ? -opdata2_i : opdata2_i;
   assign q_fix = q_neg ? -dvd : dvd;
   assign r_fix = r_neg ? -rem : rem;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .din      (dvd[WIDTH-1]),
      .dvs      (dvs),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DivFree;
         cnt      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         res      <= '0;
         ready_o  <= DivResultNotReady;
         result_o <= '0;
      end else begin
         unique case (state)
            DivFree: begin
               ready_o  <= DivResultNotReady;
               result_o <= '0;
               if (start_i == DivStart && !annul_i) begin
                  dvd   <= mag1;
                  dvs   <= mag2;
                  rem   <= '0;
                  cnt   <= '0;
                  q_neg <= neg1 ^ neg2;
                  r_neg <= neg1;
                  state <= (opdata2_i == '0) ? DivByZero : DivOn;
               end
            end
            DivByZero: begin
               if (annul_i) begin
                  state <= DivFree;
               end else begin
                  res   <= '0;
                  state <= DivEnd;
               end
            end
            DivOn: begin
               if (annul_i) begin
                  state <= DivFree;
               end else if (cnt == CW'(WIDTH)) begin
                  res   <= {r_fix, q_fix};
                  state <= DivEnd;
               end else begin
                  // dvd doubles as quotient shift register
                  dvd <= {dvd[WIDTH-2:0], q_bit};
                  rem <= rem_next;
                  cnt <= cnt + 1'b1;
               end
            end
            DivEnd: begin
               if (start_i == DivStart) begin
                  ready_o  <= DivResultReady;
                  result_o <= res;
               end else begin
                  ready_o  <= DivResultNotReady;
                  result_o <= '0;
                  state    <= DivFree;
               end
            end
            default: state <= DivFree;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit at WIDTH=32 and WIDTH=8.
module tb_div_unit;

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          t0;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sg32 = 1'b0;
   logic [31:0] a32 = '0;
   logic [31:0] b32 = '0;
   logic        start32 = 1'b0;
   logic        annul32 = 1'b0;
   logic [63:0] res32;
   logic        rdy32;

   logic        sg8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        start8 = 1'b0;
   logic        annul8 = 1'b0;
   logic [15:0] res8;
   logic        rdy8;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   exp_t sb32[$];
   exp_t sb8[$];

   div_unit #(.WIDTH(32)) dut32 (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (sg32),
      .opdata1_i    (a32),
      .opdata2_i    (b32),
      .start_i      (start32),
      .annul_i      (annul32),
      .result_o     (res32),
      .ready_o      (rdy32)
   );

   div_unit #(.WIDTH(8)) dut8 (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (sg8),
      .opdata1_i    (a8),
      .opdata2_i    (b8),
      .start_i      (start8),
      .annul_i      (annul8),
      .result_o     (res8),
      .ready_o      (rdy8)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // monitor for the 32-bit divider
   initial begin
      logic prev;
      logic [63:0] cur;
      prev = 1'b0;
      cur = '0;
      forever begin
         @(negedge clk);
         if (rdy32 && !prev) begin
            if (sb32.size() == 0) begin
               check("unexpected_ready32", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb32.pop_front();
               check("result32", res32, e.res);
               check("latency32", 64'(cyc - e.t0), 64'(e.lat));
               cur = e.res;
            end
         end else if (rdy32) begin
            check("hold32", res32, cur);
         end
         prev = rdy32;
      end
   end

   // monitor for the 8-bit divider
   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rdy8 && !prev) begin
            if (sb8.size() == 0) begin
               check("unexpected_ready8", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb8.pop_front();
               check("result8", 64'(res8), e.res);
               check("latency8", 64'(cyc - e.t0), 64'(e.lat));
            end
         end
         prev = rdy8;
      end
   end

   task automatic do_op(input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int lat, input int hold);
      int n;
      @(negedge clk);
      sg32 = sg;
      a32 = a;
      b32 = b;
      start32 = 1'b1;
      sb32.push_back('{exp, lat, cyc + 1});
      @(negedge clk);
      a32 = $urandom;
      b32 = $urandom;
      n = 0;
      while (!rdy32 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!rdy32) check("timeout32", 64'd0, 64'd1);
      repeat (hold) @(negedge clk);
      start32 = 1'b0;
      @(negedge clk);
      check("ready_fall", 64'(rdy32), 64'd0);
      check("result_clear", res32, 64'd0);
   endtask

   task automatic watch_idle(input string name, input int n);
      int seen;
      seen = 0;
      repeat (n) begin
         @(negedge clk);
         if (rdy32) seen++;
      end
      check(name, 64'(seen), 64'd0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("reset_ready", 64'(rdy32), 64'd0);
      check("reset_result", res32, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_result", res32, 64'd0);

      do_op(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, 0);
      do_op(1'b1, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0);
      do_op(1'b1, 32'd7, -32'sd2, {32'h1, 32'hFFFFFFFD}, 34, 0);
      do_op(1'b0, 32'd5, 32'd0, 64'd0, 2, 0);
      do_op(1'b1, 32'd5, 32'd0, 64'd0, 2, 0);
      do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, 0);
      do_op(1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 34, 0);
      do_op(1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 34, 0);
      do_op(1'b1, -32'sd100, -32'sd7, {32'hFFFFFFFE, 32'hE}, 34, 5);

      // flush mid-iteration, then a clean op
      @(negedge clk);
      sg32 = 1'b0;
      a32 = 32'd100;
      b32 = 32'd7;
      start32 = 1'b1;
      repeat (11) @(negedge clk);
      annul32 = 1'b1;
      start32 = 1'b0;
      @(negedge clk);
      annul32 = 1'b0;
      watch_idle("annul_no_ready", 40);
      do_op(1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 34, 0);

      // reset mid-iteration
      @(negedge clk);
      a32 = 32'd1000;
      b32 = 32'd3;
      start32 = 1'b1;
      repeat (21) @(negedge clk);
      rst = 1'b1;
      start32 = 1'b0;
      @(negedge clk);
      check("rst_mid_ready", 64'(rdy32), 64'd0);
      check("rst_mid_result", res32, 64'd0);
      rst = 1'b0;
      watch_idle("rst_no_ready", 40);

      // 8-bit signed -128/3
      @(negedge clk);
      sg8 = 1'b1;
      a8 = 8'h80;
      b8 = 8'h03;
      start8 = 1'b1;
      sb8.push_back('{64'h0000_0000_0000_FED6, 10, cyc + 1});
      n = 0;
      while (!rdy8 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!rdy8) check("timeout8", 64'd0, 64'd1);
      start8 = 1'b0;
      repeat (3) @(negedge clk);

      check("sb32_empty", 64'(sb32.size()), 64'd0);
      check("sb8_empty", 64'(sb8.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
